// File: rtl/cp0_seq.sv
// Sequencer for privileged CP0 ops (MTC0/MFC0/ERET): holds the op in ID until older
// instructions drain, then fires exactly one side effect. Optional counter: CP0_SEQ_PERF_EN.
module cp0_seq #(
   parameter int unsigned ERET_BUBBLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pipe_stall,
   input  logic        id_valid,
   input  logic        id_is_eret,
   input  logic        id_is_mtc0,
   input  logic        id_is_mfc0,
   input  logic [4:0]  id_cp0_addr,
   input  logic [31:0] id_rt_data,
   input  logic        older_busy,
   input  logic        mem_exc,
   input  logic [31:0] cp0_rdata,
   input  logic [31:0] cp0_epc,
   output logic        seq_stallD,
   output logic        seq_flush,
   output logic        cp0_we,
   output logic [4:0]  cp0_waddr,
   output logic [31:0] cp0_wdata,
   output logic [4:0]  cp0_raddr,
   output logic        mfc0_valid,
   output logic [31:0] mfc0_data,
   output logic        redirect,
   output logic [31:0] redirect_pc,
   output logic        busy,
   output logic [31:0] perf_stall_cycles
);

   typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_EXEC, S_FLUSH} state_e;
   typedef enum logic [1:0] {OP_ERET, OP_MTC0, OP_MFC0} op_e;

   localparam logic [3:0] CNT_INIT = 4'(ERET_BUBBLES - 1);

   state_e      state_q, state_d;
   op_e         op_q, op_d;
   logic [4:0]  addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        accept;

   assign accept = id_valid & (id_is_eret | id_is_mtc0 | id_is_mfc0) & ~mem_exc & ~pipe_stall;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         op_q    <= OP_ERET;
         addr_q  <= '0;
         wdata_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         cnt_q   <= cnt_d;
      end
   end

   // NOTE: every signal gets a default first, so no path through the case can infer a latch.
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      cnt_d       = cnt_q;
      seq_stallD  = 1'b0;
      seq_flush   = 1'b0;
      cp0_we      = 1'b0;
      cp0_waddr   = '0;
      cp0_wdata   = '0;
      cp0_raddr   = '0;
      mfc0_valid  = 1'b0;
      mfc0_data   = '0;
      redirect    = 1'b0;
      redirect_pc = '0;
      busy        = 1'b0;

      // Reset silences every strobe so an op in flight is abandoned without side effects.
      if (!rst) begin
         unique case (state_q)
            S_IDLE: begin
               if (accept) begin
                  seq_stallD = 1'b1;
                  state_d    = S_DRAIN;
                  op_d       = id_is_eret ? OP_ERET : (id_is_mtc0 ? OP_MTC0 : OP_MFC0);
                  addr_d     = id_cp0_addr;
                  wdata_d    = id_rt_data;
               end
            end
            S_DRAIN: begin
               seq_stallD = 1'b1;
               busy       = 1'b1;
               if (op_q == OP_MFC0) cp0_raddr = addr_q;
               if (!pipe_stall) begin
                  if (mem_exc)          state_d = S_IDLE;
                  else if (!older_busy) state_d = S_EXEC;
               end
            end
            S_EXEC: begin
               busy = 1'b1;
               if (op_q == OP_MFC0) cp0_raddr = addr_q;
               if (pipe_stall) begin
                  seq_stallD = 1'b1;
               end else if (mem_exc) begin
                  seq_stallD = 1'b1;
                  state_d    = S_IDLE;
               end else begin
                  state_d = S_IDLE;
                  unique case (op_q)
                     OP_MTC0: begin
                        cp0_we    = 1'b1;
                        cp0_waddr = addr_q;
                        cp0_wdata = wdata_q;
                     end
                     OP_MFC0: begin
                        mfc0_valid = 1'b1;
                        mfc0_data  = cp0_rdata;
                     end
                     OP_ERET: begin
                        redirect    = 1'b1;
                        redirect_pc = cp0_epc;
                        seq_flush   = 1'b1;
                        cnt_d       = CNT_INIT;
                        if (CNT_INIT != 4'd0) state_d = S_FLUSH;
                     end
                     default: state_d = S_IDLE;
                  endcase
               end
            end
            S_FLUSH: begin
               busy      = 1'b1;
               seq_flush = 1'b1;
               // cnt counts remaining bubbles; leave on the cycle it reaches zero.
               if (!pipe_stall) begin
                  cnt_d = cnt_q - 4'd1;
                  if (cnt_q <= 4'd1) state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

`ifdef CP0_SEQ_PERF_EN
   logic [31:0] perf_q, perf_d;

   always_comb begin
      perf_d = perf_q;
      if (seq_stallD && (perf_q != 32'hFFFF_FFFF)) perf_d = perf_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) perf_q <= '0;
      else     perf_q <= perf_d;
   end

   assign perf_stall_cycles = perf_q;
`else
   assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_cp0_seq.sv
// Self-checking bench for cp0_seq: directed vector table, two multi-cycle sequences,
// then random stimulus against a transaction-level reference model.
module tb_cp0_seq;

   localparam int ERET_B = 2;
   localparam int OPC_ERET = 0;
   localparam int OPC_MTC0 = 1;
   localparam int OPC_MFC0 = 2;

   logic        clk;
   logic        rst, pipe_stall, id_valid, id_is_eret, id_is_mtc0, id_is_mfc0;
   logic [4:0]  id_cp0_addr;
   logic [31:0] id_rt_data;
   logic        older_busy, mem_exc;
   logic [31:0] cp0_rdata, cp0_epc;
   logic        seq_stallD, seq_flush, cp0_we, mfc0_valid, redirect, busy;
   logic [4:0]  cp0_waddr, cp0_raddr;
   logic [31:0] cp0_wdata, mfc0_data, redirect_pc, perf_stall_cycles;

   int n_checks = 0;
   int n_fail   = 0;

   cp0_seq #(.ERET_BUBBLES(ERET_B)) dut (
      .clk(clk), .rst(rst), .pipe_stall(pipe_stall), .id_valid(id_valid),
      .id_is_eret(id_is_eret), .id_is_mtc0(id_is_mtc0), .id_is_mfc0(id_is_mfc0),
      .id_cp0_addr(id_cp0_addr), .id_rt_data(id_rt_data), .older_busy(older_busy),
      .mem_exc(mem_exc), .cp0_rdata(cp0_rdata), .cp0_epc(cp0_epc),
      .seq_stallD(seq_stallD), .seq_flush(seq_flush), .cp0_we(cp0_we),
      .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata), .cp0_raddr(cp0_raddr),
      .mfc0_valid(mfc0_valid), .mfc0_data(mfc0_data), .redirect(redirect),
      .redirect_pc(redirect_pc), .busy(busy), .perf_stall_cycles(perf_stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        i_rst, i_ps, i_v, i_e, i_t, i_f;
      logic [4:0]  i_addr;
      logic [31:0] i_rt;
      logic        i_ob, i_mx;
      logic [31:0] i_rdata, i_epc;
      logic        x_stall, x_flush, x_we;
      logic [4:0]  x_waddr;
      logic [31:0] x_wdata;
      logic [4:0]  x_raddr;
      logic        x_mv;
      logic [31:0] x_mdata;
      logic        x_rd;
      logic [31:0] x_rpc;
      logic        x_busy;
   } vec_t;

   localparam int NVEC = 29;
   vec_t tbl [NVEC];

   function automatic vec_t mk(
      input logic r, ps, v, e, t, f, input logic [4:0] a, input logic [31:0] rt,
      input logic ob, mx, input logic [31:0] rdata, epc,
      input logic st, fl, we, input logic [4:0] wa, input logic [31:0] wd,
      input logic [4:0] ra, input logic mv, input logic [31:0] md,
      input logic rd, input logic [31:0] rpc, input logic bz);
      vec_t x;
      x.i_rst = r; x.i_ps = ps; x.i_v = v; x.i_e = e; x.i_t = t; x.i_f = f;
      x.i_addr = a; x.i_rt = rt; x.i_ob = ob; x.i_mx = mx; x.i_rdata = rdata; x.i_epc = epc;
      x.x_stall = st; x.x_flush = fl; x.x_we = we; x.x_waddr = wa; x.x_wdata = wd;
      x.x_raddr = ra; x.x_mv = mv; x.x_mdata = md; x.x_rd = rd; x.x_rpc = rpc; x.x_busy = bz;
      return x;
   endfunction

   function automatic logic [127:0] outs();
      return {16'h0, seq_stallD, seq_flush, cp0_we, cp0_waddr, cp0_wdata, cp0_raddr,
              mfc0_valid, mfc0_data, redirect, redirect_pc, busy};
   endfunction

   function automatic logic [127:0] exp_of(input vec_t x);
      return {16'h0, x.x_stall, x.x_flush, x.x_we, x.x_waddr, x.x_wdata, x.x_raddr,
              x.x_mv, x.x_mdata, x.x_rd, x.x_rpc, x.x_busy};
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic put(input logic r, ps, v, e, t, f, input logic [4:0] a,
                      input logic [31:0] rt, input logic ob, mx);
      rst = r; pipe_stall = ps; id_valid = v; id_is_eret = e; id_is_mtc0 = t; id_is_mfc0 = f;
      id_cp0_addr = a; id_rt_data = rt; older_busy = ob; mem_exc = mx;
   endtask

   task automatic apply_vecs(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         put(tbl[i].i_rst, tbl[i].i_ps, tbl[i].i_v, tbl[i].i_e, tbl[i].i_t, tbl[i].i_f,
             tbl[i].i_addr, tbl[i].i_rt, tbl[i].i_ob, tbl[i].i_mx);
         cp0_rdata = tbl[i].i_rdata;
         cp0_epc   = tbl[i].i_epc;
         @(negedge clk);
         check($sformatf("vec%0d", i), outs(), exp_of(tbl[i]));
         @(posedge clk);
         #1;
      end
   endtask

   // Reference model: tracks the held instruction as a transaction, not as an FSM encoding.
   bit          m_held, m_ready;
   int          m_bub, m_op;
   logic [4:0]  m_addr;
   logic [31:0] m_data, m_perf;

   task automatic model_step(output logic [127:0] e);
      logic st, fl, we, mv, rd, bz;
      logic [4:0] wa, ra;
      logic [31:0] wd, md, rp;
      {st, fl, we, mv, rd, bz} = '0;
      wa = '0; ra = '0; wd = '0; md = '0; rp = '0;
      if (rst) begin
         m_held = 0; m_ready = 0; m_bub = 0;
      end else if (m_bub > 0) begin
         fl = 1; bz = 1;
         if (!pipe_stall) m_bub--;
      end else if (m_held) begin
         bz = 1;
         if (m_op == OPC_MFC0) ra = m_addr;
         if (!m_ready) begin
            st = 1;
            if (!pipe_stall) begin
               if (mem_exc)          m_held = 0;
               else if (!older_busy) m_ready = 1;
            end
         end else if (pipe_stall || mem_exc) begin
            st = 1;
            if (!pipe_stall) m_held = 0;
         end else begin
            m_held = 0;
            if (m_op == OPC_MTC0) begin
               we = 1; wa = m_addr; wd = m_data;
            end else if (m_op == OPC_MFC0) begin
               mv = 1; md = cp0_rdata;
            end else begin
               rd = 1; rp = cp0_epc; fl = 1; m_bub = ERET_B - 1;
            end
         end
      end else if (id_valid && (id_is_eret || id_is_mtc0 || id_is_mfc0) && !mem_exc && !pipe_stall) begin
         st = 1; m_held = 1; m_ready = 0;
         m_op = id_is_eret ? OPC_ERET : (id_is_mtc0 ? OPC_MTC0 : OPC_MFC0);
         m_addr = id_cp0_addr; m_data = id_rt_data;
      end
      e = {16'h0, st, fl, we, wa, wd, ra, mv, md, rd, rp, bz};
      if (rst) m_perf = '0;
      else if (st && m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 32'd1;
   endtask

   initial begin
      int we_cnt, we_cyc, side_cnt;
      logic [4:0]  we_addr;
      logic [31:0] we_data, perf_exp;
      logic [127:0] e;

      put(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cp0_rdata = '0; cp0_epc = '0;

      //            rst ps v e t f addr rt            ob mx rdata          epc           | st fl we wa wd            ra mv md             rd rpc           bz
      tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0,  0,            0, 0, 0,             0,            0, 0, 0, 0,  0,            0,  0, 0,            0, 0,            0);
      tbl[1]  = mk(1, 0, 0, 0, 0, 0, 0,  0,            0, 0, 0,             0,            0, 0, 0, 0,  0,            0,  0, 0,            0, 0,            0);
      tbl[2]  = mk(0, 0, 1, 0, 1, 0, 12, 32'h0000FF01, 0, 0, 0,             0,            1, 0, 0, 0,  0,            0,  0, 0,            0, 0,            0);
      tbl[3]  = mk(0, 0, 1, 0, 1, 0, 12, 32'h0000FF01, 0, 0, 0,             0,            1, 0, 0, 0,  0,            0,  0, 0,            0, 0,            1);
      tbl[4]  = mk(0, 0, 1, 0, 1, 0, 12, 32'h0000FF01, 0, 0, 0,             0,            0, 0, 1, 12, 32'h0000FF01, 0,  0, 0,            0, 0,            1);
      tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0,  0,            0, 0, 0,             0,            0, 0, 0, 0,  0,            0,  0, 0,            0, 0,            0);
      tbl[6]  = mk(1, 0, 0, 0, 0, 0, 0,  0,            0, 0, 0,             0,            0, 0, 0, 0,  0,            0,  0, 0,            0, 0,            0);
      tbl[7]  = mk(0, 0, 1, 0, 0, 1, 14, 0,            1, 0, 32'hBFC00380, 0,            1, 0, 0, 0,  0,            0,  0, 0,            0, 0,            0);
      tbl[8]  = mk(0, 0, 1, 0, 0, 1, 14, 0,            1, 0, 32'hBFC00380, 0,            1, 0, 0, 0,  0,            14, 0, 0,            0, 0,            1);
      tbl[9]  = mk(0, 0, 1, 0, 0, 1, 14, 0,            1, 0, 32'hBFC00380, 0,            1, 0, 0, 0,  0,            14, 0, 0,            0, 0,            1);
      tbl[10] = mk(0, 0, 1, 0, 0, 1, 14, 0,            1, 0, 32'hBFC00380, 0,            1, 0, 0, 0,  0,            14, 0, 0,            0, 0,            1);
      tbl[11] = mk(0, 0, 1, 0, 0, 1, 14, 0,            0, 0, 32'hBFC00380, 0,            1, 0, 0, 0,  0,            14, 0, 0,            0, 0,            1);
      tbl[12] = mk(0, 0, 1, 0, 0, 1, 14, 0,            0, 0, 32'hBFC00380, 0,            0, 0, 0, 0,  0,            14, 1, 32'hBFC00380, 0, 0,            1);
      tbl[13] = mk(0, 0, 0, 0, 0, 0, 0,  0,            0, 0, 32'hBFC00380, 0,            0, 0, 0, 0,  0,            0,  0, 0,            0, 0,            0);
      tbl[14] = mk(0, 0, 1, 1, 1, 0, 5,  0,            0, 0, 0,             32'h80001234, 1, 0, 0, 0,  0,            0,  0, 0,            0, 0,            0);
      tbl[15] = mk(0, 0, 1, 1, 1, 0, 5,  0,            0, 0, 0,             32'h80001234, 1, 0, 0, 0,  0,            0,  0, 0,            0, 0,            1);
      tbl[16] = mk(0, 0, 1, 1, 1, 0, 5,  0,            0, 0, 0,             32'h80001234, 0, 1, 0, 0,  0,            0,  0, 0,            1, 32'h80001234, 1);
      tbl[17] = mk(0, 0, 0, 0, 0, 0, 0,  0,            0, 0, 0,             32'h80001234, 0, 1, 0, 0,  0,            0,  0, 0,            0, 0,            1);
      tbl[18] = mk(0, 0, 0, 0, 0, 0, 0,  0,            0, 0, 0,             32'h80001234, 0, 0, 0, 0,  0,            0,  0, 0,            0, 0,            0);
      tbl[19] = mk(0, 0, 1, 0, 1, 0, 3,  32'h0000DEAD, 0, 0, 0,             0,            1, 0, 0, 0,  0,            0,  0, 0,            0, 0,            0);
      tbl[20] = mk(0, 0, 1, 0, 1, 0, 3,  32'h0000DEAD, 0, 1, 0,             0,            1, 0, 0, 0,  0,            0,  0, 0,            0, 0,            1);
      tbl[21] = mk(0, 0, 0, 0, 0, 0, 0,  0,            0, 0, 0,             0,            0, 0, 0, 0,  0,            0,  0, 0,            0, 0,            0);
      tbl[22] = mk(0, 0, 0, 0, 0, 0, 0,  0,            0, 0, 0,             0,            0, 0, 0, 0,  0,            0,  0, 0,            0, 0,            0);
      tbl[23] = mk(0, 0, 1, 0, 1, 1, 9,  32'h00000055, 0, 0, 0,             0,            1, 0, 0, 0,  0,            0,  0, 0,            0, 0,            0);
      tbl[24] = mk(0, 0, 1, 0, 1, 1, 9,  32'h00000055, 0, 0, 0,             0,            1, 0, 0, 0,  0,            0,  0, 0,            0, 0,            1);
      tbl[25] = mk(0, 0, 1, 0, 1, 1, 9,  32'h00000055, 0, 0, 0,             0,            0, 0, 1, 9,  32'h00000055, 0,  0, 0,            0, 0,            1);
      tbl[26] = mk(0, 0, 0, 0, 0, 0, 0,  0,            0, 0, 0,             0,            0, 0, 0, 0,  0,            0,  0, 0,            0, 0,            0);
      tbl[27] = mk(0, 0, 1, 0, 0, 1, 2,  0,            0, 1, 0,             0,            0, 0, 0, 0,  0,            0,  0, 0,            0, 0,            0);
      tbl[28] = mk(0, 0, 0, 0, 0, 0, 0,  0,            0, 0, 0,             0,            0, 0, 0, 0,  0,            0,  0, 0,            0, 0,            0);

      @(posedge clk);
      #1;
      apply_vecs(0, 13);
`ifdef CP0_SEQ_PERF_EN
      perf_exp = 32'd5;
`else
      perf_exp = 32'd0;
`endif
      check("perf_after_mfc0", 128'(perf_stall_cycles), 128'(perf_exp));
      apply_vecs(14, NVEC - 1);

      // MTC0 frozen by pipe_stall for two cycles in EXEC.
      we_cnt = 0; we_cyc = -1; we_addr = '0; we_data = '0;
      for (int c = 0; c < 8; c++) begin
         if (c <= 4) put(0, (c == 2 || c == 3), 1, 0, 1, 0, 7, 32'hA5A50001, 0, 0);
         else        put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
         @(negedge clk);
         if (cp0_we) begin
            we_cnt++; we_cyc = c; we_addr = cp0_waddr; we_data = cp0_wdata;
         end
         @(posedge clk);
         #1;
      end
      check("ps_exec_we_count", 128'(we_cnt), 128'(1));
      check("ps_exec_we_cycle", 128'(we_cyc), 128'(4));
      check("ps_exec_we_addr", 128'(we_addr), 128'(7));
      check("ps_exec_we_data", 128'(we_data), 128'(32'hA5A50001));

      // Reset while the op waits in DRAIN.
      side_cnt = 0;
      for (int c = 0; c < 8; c++) begin
         if (c == 0 || c == 1) put(0, 0, 1, 0, 1, 0, 4, 32'h00001234, 1, 0);
         else if (c == 2)      put(1, 0, 1, 0, 1, 0, 4, 32'h00001234, 0, 0);
         else                  put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
         @(negedge clk);
         if (cp0_we || redirect) side_cnt++;
         if (c == 3) begin
            check("rst_drain_outs", outs(), 128'h0);
            check("rst_drain_perf", 128'(perf_stall_cycles), 128'h0);
         end
         @(posedge clk);
         #1;
      end
      check("rst_drain_side_effects", 128'(side_cnt), 128'(0));

      // Random stimulus against the model, starting from a clean reset.
      put(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      m_held = 0; m_ready = 0; m_bub = 0; m_op = 0; m_addr = '0; m_data = '0; m_perf = '0;
      for (int i = 0; i < 3000; i++) begin
         put(($urandom_range(0, 63) == 0), ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
             5'($urandom), $urandom, $urandom_range(0, 1) == 1, ($urandom_range(0, 11) == 0));
         cp0_rdata = $urandom;
         cp0_epc   = $urandom;
`ifdef CP0_SEQ_PERF_EN
         perf_exp = m_perf;
`else
         perf_exp = 32'd0;
`endif
         model_step(e);
         @(negedge clk);
         check("rand_outs", outs(), e);
         check("rand_perf", 128'(perf_stall_cycles), 128'(perf_exp));
         @(posedge clk);
         #1;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
